irq_responder: RTL and testbench

- CPU-side end of the interrupt protocol driven by the IO controller (IRQ level plus 4-bit IDN).
- Holds the system registers PCS, IHA, IRA and IDN, and samples IRQ at instruction commit.
- Saves the return PC and old IE, then issues a registered redirect to the handler address and squashes in-flight work for a fixed flush window.
- Services RETI, RSR and WSR, and drives IE back to the device side.

---
 rtl/irq_responder_pkg.sv | 20 ++
 rtl/irq_sysregs.sv | 72 +++++++
 rtl/irq_responder.sv | 117 +++++++++++
 tb/tb_irq_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/irq_responder_pkg.sv
// Shared definitions for the CPU-side interrupt responder: system register
// indices, PCS bit layout and FSM state encoding.
package irq_responder_pkg;

    localparam logic [3:0] SR_PCS   = 4'd0;
    localparam logic [3:0] SR_IHA   = 4'd1;
    localparam logic [3:0] SR_IRA   = 4'd2;
    localparam logic [3:0] SR_IDN   = 4'd3;

    localparam int         PCS_IE   = 0;
    localparam int         PCS_OIE  = 1;

    localparam logic [3:0] IDN_NONE = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/irq_sysregs.sv
// System registers PCS/IHA/IRA/IDN with a read-old combinational read port,
// a software write port and the hardware take/return update paths.
module irq_sysregs
    import irq_responder_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter logic [DBITS-1:0] RESET_IHA = 'h100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [3:0]       i_wr_idx,
    input  logic [DBITS-1:0] i_wr_data,
    input  logic             i_take,
    input  logic [DBITS-1:0] i_take_pc,
    input  logic [3:0]       i_take_idn,
    input  logic             i_reti,
    input  logic [3:0]       i_rd_idx,
    output logic [DBITS-1:0] o_rd_data,
    output logic             o_ie,
    output logic [DBITS-1:0] o_iha,
    output logic [DBITS-1:0] o_ira
);

    logic [1:0]       r_pcs;
    logic [DBITS-1:0] r_iha;
    logic [DBITS-1:0] r_ira;
    logic [3:0]       r_idn;
    logic [DBITS-1:0] w_rd_data;

    // The FSM guarantees at most one of take/reti/wr_en per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcs <= 2'b00;
            r_iha <= RESET_IHA;
            r_ira <= '0;
            r_idn <= IDN_NONE;
        end else if (i_take) begin
            r_ira          <= i_take_pc;
            r_pcs[PCS_OIE] <= r_pcs[PCS_IE];
            r_pcs[PCS_IE]  <= 1'b0;
            r_idn          <= i_take_idn;
        end else if (i_reti) begin
            r_pcs[PCS_IE]  <= r_pcs[PCS_OIE];
        end else if (i_wr_en) begin
            case (i_wr_idx)
                SR_PCS:  r_pcs <= i_wr_data[1:0];
                SR_IHA:  r_iha <= i_wr_data;
                SR_IRA:  r_ira <= i_wr_data;
                SR_IDN:  r_idn <= i_wr_data[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (i_rd_idx)
            SR_PCS:  w_rd_data = {{(DBITS-2){1'b0}}, r_pcs};
            SR_IHA:  w_rd_data = r_iha;
            SR_IRA:  w_rd_data = r_ira;
            SR_IDN:  w_rd_data = {{(DBITS-4){1'b0}}, r_idn};
            default: w_rd_data = '0;
        endcase
    end

    assign o_rd_data = w_rd_data;
    assign o_ie      = r_pcs[PCS_IE];
    assign o_iha     = r_iha;
    assign o_ira     = r_ira;

endmodule

// File: rtl/irq_responder.sv
// CPU-side interrupt responder: samples IRQ at commit, services RETI/WSR,
// issues a registered redirect and holds a fixed flush window afterwards.
module irq_responder
    import irq_responder_pkg::*;
#(
    parameter int               DBITS        = 32,
    parameter logic [DBITS-1:0] RESET_IHA    = 32'h00000100,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irq,
    input  logic [3:0]       idn,
    input  logic             commit_valid,
    input  logic [DBITS-1:0] commit_next_pc,
    input  logic             is_reti,
    input  logic             is_wsr,
    input  logic [3:0]       sr_index,
    input  logic [DBITS-1:0] wsr_data,
    output logic [DBITS-1:0] rsr_data,
    output logic             ie,
    output logic             redirect,
    output logic [DBITS-1:0] redirect_pc,
    output logic             flush
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_redirect, w_redirect_nxt;
    logic [DBITS-1:0] r_redirect_pc, w_redirect_pc_nxt;
    logic             w_take, w_reti, w_wsr;
    logic             w_ie;
    logic [DBITS-1:0] w_iha, w_ira;

    irq_sysregs #(
        .DBITS     (DBITS),
        .RESET_IHA (RESET_IHA)
    ) u_sysregs (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wsr),
        .i_wr_idx   (sr_index),
        .i_wr_data  (wsr_data),
        .i_take     (w_take),
        .i_take_pc  (commit_next_pc),
        .i_take_idn (idn),
        .i_reti     (w_reti),
        .i_rd_idx   (sr_index),
        .o_rd_data  (rsr_data),
        .o_ie       (w_ie),
        .o_iha      (w_iha),
        .o_ira      (w_ira)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
        end
    end

    // RETI outranks WSR outranks interrupt take; a WSR to PCS only affects
    // the take decision from the following cycle on.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_redirect_nxt    = 1'b0;
        w_redirect_pc_nxt = r_redirect_pc;
        w_take            = 1'b0;
        w_reti            = 1'b0;
        w_wsr             = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (commit_valid && is_reti) begin
                    w_reti            = 1'b1;
                    w_redirect_nxt    = 1'b1;
                    w_redirect_pc_nxt = w_ira;
                    w_state_nxt       = ST_FLUSH;
                    w_cnt_nxt         = FLUSH_INIT;
                end else if (commit_valid && is_wsr) begin
                    w_wsr = 1'b1;
                end else if (commit_valid && irq && w_ie) begin
                    w_take            = 1'b1;
                    w_redirect_nxt    = 1'b1;
                    w_redirect_pc_nxt = w_iha;
                    w_state_nxt       = ST_FLUSH;
                    w_cnt_nxt         = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign ie          = w_ie;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign flush       = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_irq_responder.sv
// Directed vector bench for irq_responder: a table of per-cycle stimulus and
// expected post-edge outputs, followed by masked-request and reset-in-flush sequences.
module tb_irq_responder;

    typedef struct {
        logic        rst;
        logic        irq;
        logic [3:0]  idn;
        logic        cv;
        logic [31:0] npc;
        logic        reti;
        logic        wsr;
        logic [3:0]  idx;
        logic [31:0] wd;
        logic        e_ie;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_fl;
        logic [31:0] e_rsr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, irq, commit_valid, is_reti, is_wsr;
    logic [3:0]  idn, sr_index;
    logic [31:0] commit_next_pc, wsr_data, rsr_data, redirect_pc;
    logic        ie, redirect, flush;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    irq_responder #(
        .DBITS        (32),
        .RESET_IHA    (32'h00000100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .idn            (idn),
        .commit_valid   (commit_valid),
        .commit_next_pc (commit_next_pc),
        .is_reti        (is_reti),
        .is_wsr         (is_wsr),
        .sr_index       (sr_index),
        .wsr_data       (wsr_data),
        .rsr_data       (rsr_data),
        .ie             (ie),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic q, logic [3:0] d, logic c,
                                logic [31:0] pc, logic rt, logic w,
                                logic [3:0] ix, logic [31:0] wdat,
                                logic eie, logic ered, logic [31:0] erpc,
                                logic efl, logic [31:0] ersr);
        vec_t v;
        v.rst = r; v.irq = q; v.idn = d; v.cv = c; v.npc = pc;
        v.reti = rt; v.wsr = w; v.idx = ix; v.wd = wdat;
        v.e_ie = eie; v.e_red = ered; v.e_rpc = erpc; v.e_fl = efl; v.e_rsr = ersr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input vec_t v);
        rst = v.rst; irq = v.irq; idn = v.idn; commit_valid = v.cv;
        commit_next_pc = v.npc; is_reti = v.reti; is_wsr = v.wsr;
        sr_index = v.idx; wsr_data = v.wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // rst irq idn cv npc reti wsr idx wd | ie red rpc fl rsr
        tbl.push_back(mk(1,1,2,1,32'h0 ,0,0,1,32'h0, 0,0,32'h0,0,32'h100));
        tbl.push_back(mk(1,0,0,0,32'h0 ,0,0,3,32'h0, 0,0,32'h0,0,32'hF));
        tbl.push_back(mk(0,1,2,1,32'h10,0,0,2,32'h0, 0,0,32'h0,0,32'h0));
        tbl.push_back(mk(0,0,0,1,32'h0 ,0,1,7,32'hFFFFFFFF, 0,0,32'h0,0,32'h0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,0,32'h0, 0,0,32'h0,0,32'h0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,1,32'h0, 0,0,32'h0,0,32'h100));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,2,32'h0, 0,0,32'h0,0,32'h0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,3,32'h0, 0,0,32'h0,0,32'hF));
        tbl.push_back(mk(0,1,1,1,32'h40,0,1,0,32'h1, 1,0,32'h0,0,32'h1));
        tbl.push_back(mk(0,1,1,0,32'h0 ,0,0,0,32'h0, 1,0,32'h0,0,32'h1));
        tbl.push_back(mk(0,1,1,1,32'h48,0,0,2,32'h0, 0,1,32'h100,1,32'h48));
        tbl.push_back(mk(0,1,1,1,32'h4C,1,0,0,32'h0, 0,0,32'h0,1,32'h2));
        tbl.push_back(mk(0,1,1,1,32'h4C,0,0,3,32'h0, 0,0,32'h0,0,32'h1));
        tbl.push_back(mk(0,0,0,1,32'h50,1,0,0,32'h0, 1,1,32'h48,1,32'h3));
        tbl.push_back(mk(0,1,5,1,32'h60,0,0,2,32'h0, 1,0,32'h0,1,32'h48));
        tbl.push_back(mk(0,1,5,1,32'h64,0,0,2,32'h0, 1,0,32'h0,0,32'h48));
        tbl.push_back(mk(0,1,5,1,32'h68,0,0,2,32'h0, 0,1,32'h100,1,32'h68));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,3,32'h0, 0,0,32'h0,1,32'h5));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,3,32'h0, 0,0,32'h0,0,32'h5));
        tbl.push_back(mk(0,1,7,1,32'h70,0,1,0,32'h3, 1,0,32'h0,0,32'h3));
        tbl.push_back(mk(0,1,7,1,32'h80,1,0,2,32'h0, 1,1,32'h68,1,32'h68));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,3,32'h0, 1,0,32'h0,1,32'h5));
        tbl.push_back(mk(0,0,0,0,32'h0 ,0,0,3,32'h0, 1,0,32'h0,0,32'h5));
        tbl.push_back(mk(0,1,3,1,32'h90,0,1,1,32'h200, 1,0,32'h0,0,32'h200));
        tbl.push_back(mk(0,1,3,1,32'h94,0,0,3,32'h0, 0,1,32'h200,1,32'h3));
        tbl.push_back(mk(1,0,0,0,32'h0 ,0,0,1,32'h0, 0,0,32'h0,0,32'h100));

        foreach (tbl[i]) begin
            step(tbl[i]);
            chk($sformatf("row%0d ie", i),       {31'b0, ie},       {31'b0, tbl[i].e_ie});
            chk($sformatf("row%0d redirect", i), {31'b0, redirect}, {31'b0, tbl[i].e_red});
            chk($sformatf("row%0d flush", i),    {31'b0, flush},    {31'b0, tbl[i].e_fl});
            chk($sformatf("row%0d rsr", i),      rsr_data,          tbl[i].e_rsr);
            if (tbl[i].e_red)
                chk($sformatf("row%0d redirect_pc", i), redirect_pc, tbl[i].e_rpc);
        end

        // Masked level request held across ten commits: never taken.
        for (int k = 0; k < 10; k++) begin
            step(mk(0,1,4,1,32'h100 + 32'(k*4),0,0,0,32'h0, 0,0,32'h0,0,32'h0));
            chk($sformatf("masked%0d redirect", k), {31'b0, redirect}, 32'h0);
        end
        // WSR enabling IE is not itself a take point; the next commit is.
        step(mk(0,1,4,1,32'h200,0,1,0,32'h1, 0,0,32'h0,0,32'h0));
        chk("wsr_ie redirect", {31'b0, redirect}, 32'h0);
        chk("wsr_ie ie", {31'b0, ie}, 32'h1);
        step(mk(0,1,4,1,32'h300,0,0,2,32'h0, 0,0,32'h0,0,32'h0));
        chk("late_take redirect", {31'b0, redirect}, 32'h1);
        chk("late_take redirect_pc", redirect_pc, 32'h100);
        chk("late_take ira", rsr_data, 32'h300);

        // Reset asserted in the second flush cycle.
        step(mk(0,1,4,1,32'h304,0,0,3,32'h0, 0,0,32'h0,0,32'h0));
        chk("flush1 flush", {31'b0, flush}, 32'h1);
        chk("flush1 idn", rsr_data, 32'h4);
        step(mk(1,1,4,1,32'h308,0,0,2,32'h0, 0,0,32'h0,0,32'h0));
        chk("rst_flush flush", {31'b0, flush}, 32'h0);
        chk("rst_flush redirect", {31'b0, redirect}, 32'h0);
        chk("rst_flush ira", rsr_data, 32'h0);

        // Reset asserted in the first flush cycle must also end the window.
        step(mk(0,1,4,1,32'h0,0,1,0,32'h1, 0,0,32'h0,0,32'h0));
        step(mk(0,1,6,1,32'h400,0,0,3,32'h0, 0,0,32'h0,0,32'h0));
        chk("take2 redirect", {31'b0, redirect}, 32'h1);
        chk("take2 idn", rsr_data, 32'h6);
        step(mk(1,0,0,0,32'h0,0,0,0,32'h0, 0,0,32'h0,0,32'h0));
        chk("rst_early flush", {31'b0, flush}, 32'h0);
        chk("rst_early pcs", rsr_data, 32'h0);
        // Back in IDLE: a WSR followed by a qualifying commit is taken at once.
        step(mk(0,0,0,1,32'h0,0,1,0,32'h1, 0,0,32'h0,0,32'h0));
        v = mk(0,1,2,1,32'h500,0,0,2,32'h0, 0,0,32'h0,0,32'h0);
        step(v);
        chk("post_rst take redirect", {31'b0, redirect}, 32'h1);
        chk("post_rst take ira", rsr_data, 32'h500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
